// File: rtl/mor1kx_wb_arb_pkg.sv
// Shared encodings for the mor1kx N-master Wishbone arbiter.
package mor1kx_wb_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam logic [2:0] CTI_CLASSIC   = 3'b000;
   localparam logic [2:0] CTI_INC_BURST = 3'b010;
   localparam logic [2:0] CTI_END_BURST = 3'b111;

   localparam string ARB_ROUND_ROBIN = "ROUND_ROBIN";
   localparam string ARB_FIXED       = "FIXED";

endpackage

// File: rtl/mor1kx_wb_arb_rr.sv
// Combinational one-hot picker: round-robin starting after last, or fixed lowest-index-first.
module mor1kx_wb_arb_rr
   import mor1kx_wb_arb_pkg::*;
#(
   parameter int NUM   = 2,
   parameter int IDX_W = 1
) (
   input  logic [NUM-1:0]   req,
   input  logic [IDX_W-1:0] last,
   input  logic             rr_mode,
   output logic [NUM-1:0]   gnt,
   output logic [IDX_W-1:0] idx
);

   int cand;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves a latch behind.
      gnt  = '0;
      idx  = '0;
      cand = 0;
      // Scan from lowest to highest priority; the final hit is the winner.
      for (int i = NUM; i >= 1; i--) begin
         cand = rr_mode ? (int'(last) + i) % NUM : i - 1;
         if (req[cand]) begin
            gnt       = '0;
            gnt[cand] = 1'b1;
            idx       = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/mor1kx_wb_arbiter.sv
// N-master to 1-slave Wishbone B3 arbiter: registered grant held for the whole cycle, with a stall watchdog.
module mor1kx_wb_arbiter
   import mor1kx_wb_arb_pkg::*;
#(
   parameter int    NUM_MASTERS    = 2,
   parameter int    ADDR_WIDTH     = 32,
   parameter int    DATA_WIDTH     = 32,
   parameter string ARB_MODE       = "ROUND_ROBIN",
   parameter int    TIMEOUT_CYCLES = 255
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
   input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
   input  logic [NUM_MASTERS-1:0]              m_we_i,
   input  logic [NUM_MASTERS-1:0]              m_cyc_i,
   input  logic [NUM_MASTERS-1:0]              m_stb_i,
   input  logic [NUM_MASTERS*3-1:0]            m_cti_i,
   input  logic [NUM_MASTERS*2-1:0]            m_bte_i,
   output logic [DATA_WIDTH-1:0]               m_dat_o,
   output logic [NUM_MASTERS-1:0]              m_ack_o,
   output logic [NUM_MASTERS-1:0]              m_err_o,
   output logic [NUM_MASTERS-1:0]              m_rty_o,
   output logic [ADDR_WIDTH-1:0]               s_adr_o,
   output logic [DATA_WIDTH-1:0]               s_dat_o,
   output logic [DATA_WIDTH/8-1:0]             s_sel_o,
   output logic                                s_we_o,
   output logic                                s_cyc_o,
   output logic                                s_stb_o,
   output logic [2:0]                          s_cti_o,
   output logic [1:0]                          s_bte_o,
   input  logic [DATA_WIDTH-1:0]               s_dat_i,
   input  logic                                s_ack_i,
   input  logic                                s_err_i,
   input  logic                                s_rty_i,
   output logic [NUM_MASTERS-1:0]              grant_o
);

   localparam int          IDX_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int          SEL_W   = DATA_WIDTH / 8;
   localparam logic        RR_MODE = (ARB_MODE == ARB_ROUND_ROBIN);
   localparam logic        WD_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

   arb_state_t             state;
   logic [NUM_MASTERS-1:0] grant;
   logic [IDX_W-1:0]       gnt_idx;
   logic [IDX_W-1:0]       last;
   logic [15:0]            count;

   logic [NUM_MASTERS-1:0] pick_gnt;
   logic [IDX_W-1:0]       pick_idx;
   logic                   busy;
   logic                   cyc_g;
   logic                   stb_g;
   logic                   term;
   logic                   fire;

   mor1kx_wb_arb_rr #(
      .NUM   (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (m_cyc_i),
      .last    (last),
      .rr_mode (RR_MODE),
      .gnt     (pick_gnt),
      .idx     (pick_idx)
   );

   assign busy = (state == BUSY);
   assign term = s_ack_i | s_err_i | s_rty_i;
   // A genuine termination in the timeout cycle wins over the forced error.
   assign fire = WD_EN && busy && stb_g && (count == TIMEOUT) && !term;

   always_comb begin
      cyc_g   = 1'b0;
      stb_g   = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      s_cti_o = '0;
      s_bte_o = '0;
      if (busy) begin
         cyc_g   = m_cyc_i[gnt_idx];
         stb_g   = m_stb_i[gnt_idx];
         s_adr_o = m_adr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         s_dat_o = m_dat_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
         s_sel_o = m_sel_i[int'(gnt_idx)*SEL_W +: SEL_W];
         s_we_o  = m_we_i[gnt_idx];
         s_cti_o = m_cti_i[int'(gnt_idx)*3 +: 3];
         s_bte_o = m_bte_i[int'(gnt_idx)*2 +: 2];
      end
   end

   assign s_cyc_o = cyc_g;
   assign s_stb_o = stb_g & ~fire;
   assign m_dat_o = busy ? s_dat_i : '0;
   assign grant_o = grant;

   always_comb begin
      m_ack_o = '0;
      m_err_o = '0;
      m_rty_o = '0;
      if (busy) begin
         m_ack_o[gnt_idx] = s_ack_i & stb_g;
         m_err_o[gnt_idx] = (s_err_i & stb_g) | fire;
         m_rty_o[gnt_idx] = s_rty_i & stb_g;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         grant   <= '0;
         gnt_idx <= '0;
         last    <= IDX_W'(NUM_MASTERS - 1);
         count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               count <= '0;
               if (|m_cyc_i) begin
                  state   <= BUSY;
                  grant   <= pick_gnt;
                  gnt_idx <= pick_idx;
                  last    <= pick_idx;
               end
            end
            BUSY: begin
               if (!cyc_g) begin
                  state <= IDLE;
                  grant <= '0;
                  count <= '0;
               end else if (!WD_EN || term || fire) begin
                  count <= '0;
               end else if (stb_g) begin
                  count <= count + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mor1kx_wb_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share stimulus and are compared against a cycle-level model.
module tb_mor1kx_wb_arbiter;
   import mor1kx_wb_arb_pkg::*;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N*AW-1:0] m_adr;
   logic [N*DW-1:0] m_dat;
   logic [N*SW-1:0] m_sel;
   logic [N-1:0]    m_we, m_cyc, m_stb;
   logic [N*3-1:0]  m_cti;
   logic [N*2-1:0]  m_bte;
   logic [DW-1:0]   s_dat;
   logic            s_ack, s_err, s_rty;

   // Index 0: round-robin instance, index 1: fixed-priority instance.
   logic [DW-1:0] o_m_dat [2];
   logic [N-1:0]  o_ack   [2];
   logic [N-1:0]  o_err   [2];
   logic [N-1:0]  o_rty   [2];
   logic [N-1:0]  o_grant [2];
   logic [AW-1:0] o_s_adr [2];
   logic [DW-1:0] o_s_dat [2];
   logic [SW-1:0] o_s_sel [2];
   logic          o_s_we  [2];
   logic          o_s_cyc [2];
   logic          o_s_stb [2];
   logic [2:0]    o_s_cti [2];
   logic [1:0]    o_s_bte [2];

   mor1kx_wb_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .ARB_MODE("ROUND_ROBIN"), .TIMEOUT_CYCLES(TO)) dut_rr (
      .clk(clk), .rst(rst),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
      .m_dat_o(o_m_dat[0]), .m_ack_o(o_ack[0]), .m_err_o(o_err[0]), .m_rty_o(o_rty[0]),
      .s_adr_o(o_s_adr[0]), .s_dat_o(o_s_dat[0]), .s_sel_o(o_s_sel[0]), .s_we_o(o_s_we[0]),
      .s_cyc_o(o_s_cyc[0]), .s_stb_o(o_s_stb[0]), .s_cti_o(o_s_cti[0]), .s_bte_o(o_s_bte[0]),
      .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
      .grant_o(o_grant[0])
   );

   mor1kx_wb_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .ARB_MODE("FIXED"), .TIMEOUT_CYCLES(TO)) dut_fx (
      .clk(clk), .rst(rst),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
      .m_dat_o(o_m_dat[1]), .m_ack_o(o_ack[1]), .m_err_o(o_err[1]), .m_rty_o(o_rty[1]),
      .s_adr_o(o_s_adr[1]), .s_dat_o(o_s_dat[1]), .s_sel_o(o_s_sel[1]), .s_we_o(o_s_we[1]),
      .s_cyc_o(o_s_cyc[1]), .s_stb_o(o_s_stb[1]), .s_cti_o(o_s_cti[1]), .s_bte_o(o_s_bte[1]),
      .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
      .grant_o(o_grant[1])
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Model: owner is the granted master (-1 when none), last the most recent winner,
   // stall the number of consecutive unanswered strobe cycles of the current transfer.
   int owner [2];
   int last  [2];
   int stall [2];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         owner[d] = -1;
         last[d]  = N - 1;
         stall[d] = 0;
      end
   endtask

   function automatic bit timed_out(input int d);
      int g;
      g = owner[d];
      if (g < 0) return 1'b0;
      return m_stb[g] && (stall[d] == TO) && !(s_ack || s_err || s_rty);
   endfunction

   task automatic model_update();
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            owner[d] = -1;
            last[d]  = N - 1;
            stall[d] = 0;
         end else if (owner[d] < 0) begin
            stall[d] = 0;
            for (int off = 1; off <= N; off++) begin
               int c;
               c = (d == 0) ? (last[d] + off) % N : off - 1;
               if (m_cyc[c]) begin
                  owner[d] = c;
                  last[d]  = c;
                  break;
               end
            end
         end else begin
            int  g;
            bit  t;
            g = owner[d];
            t = timed_out(d);
            if (!m_cyc[g]) begin
               owner[d] = -1;
               stall[d] = 0;
            end else if (s_ack || s_err || s_rty || t) begin
               stall[d] = 0;
            end else if (m_stb[g]) begin
               stall[d] = stall[d] + 1;
            end
         end
      end
   endtask

   task automatic model_compare();
      for (int d = 0; d < 2; d++) begin
         string      p;
         int         g;
         bit         t;
         logic [N-1:0] one;
         logic [63:0]  e_adr, e_dat, e_ctl, e_mdat;
         bit           e_cyc, e_stb;
         p     = (d == 0) ? "rr" : "fx";
         g     = owner[d];
         t     = timed_out(d);
         one   = '0;
         e_adr = '0; e_dat = '0; e_ctl = '0; e_mdat = '0;
         e_cyc = 1'b0; e_stb = 1'b0;
         if (g >= 0) begin
            one[g] = 1'b1;
            e_cyc  = m_cyc[g];
            e_stb  = m_stb[g] && !t;
            e_adr  = 64'(m_adr[g*AW +: AW]);
            e_dat  = 64'(m_dat[g*DW +: DW]);
            e_ctl  = 64'({m_we[g], m_sel[g*SW +: SW], m_cti[g*3 +: 3], m_bte[g*2 +: 2]});
            e_mdat = 64'(s_dat);
         end
         check({p, ".grant"}, 64'(o_grant[d]), 64'(one));
         check({p, ".s_cyc"}, 64'(o_s_cyc[d]), 64'(e_cyc));
         check({p, ".s_stb"}, 64'(o_s_stb[d]), 64'(e_stb));
         check({p, ".s_adr"}, 64'(o_s_adr[d]), e_adr);
         check({p, ".s_dat"}, 64'(o_s_dat[d]), e_dat);
         check({p, ".s_ctl"}, 64'({o_s_we[d], o_s_sel[d], o_s_cti[d], o_s_bte[d]}), e_ctl);
         check({p, ".m_dat"}, 64'(o_m_dat[d]), e_mdat);
         check({p, ".m_ack"}, 64'(o_ack[d]), (g >= 0 && s_ack && m_stb[g]) ? 64'(one) : 64'd0);
         check({p, ".m_err"}, 64'(o_err[d]), (g >= 0 && ((s_err && m_stb[g]) || t)) ? 64'(one) : 64'd0);
         check({p, ".m_rty"}, 64'(o_rty[d]), (g >= 0 && s_rty && m_stb[g]) ? 64'(one) : 64'd0);
      end
   endtask

   task automatic half();
      @(negedge clk);
      model_compare();
   endtask

   task automatic edge_();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic cyc1();
      half();
      edge_();
   endtask

   task automatic clear_inputs();
      m_cyc = '0; m_stb = '0; m_we = '0; m_cti = '0; m_bte = '0;
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      model_reset();
      cyc1();
      rst = 1'b0;
   endtask

   logic [N-1:0] gseq[$];

   // Both masters keep requesting; a master drops cyc for one cycle after each ack.
   task automatic contend(input int d, input int max_cyc);
      logic [N-1:0] dropped;
      logic [N-1:0] prev;
      dropped = '0;
      prev    = '0;
      gseq.delete();
      for (int i = 0; i < max_cyc && gseq.size() < 4; i++) begin
         m_cyc = ~dropped;
         m_stb = ~dropped;
         #1;
         s_ack = o_s_stb[d];
         half();
         if (o_grant[d] != '0 && prev == '0) gseq.push_back(o_grant[d]);
         prev    = o_grant[d];
         dropped = o_ack[d];
         edge_();
      end
      s_ack = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      int  beats;
      bit  found;
      m_adr = '0; m_dat = '0; m_sel = '0; s_dat = '0;
      clear_inputs();
      rst = 1'b1;
      model_reset();
      repeat (2) cyc1();

      half();
      check("reset.grant", 64'(o_grant[0]), 64'd0);
      check("reset.s_cyc", 64'(o_s_cyc[0]), 64'd0);
      check("reset.s_stb", 64'(o_s_stb[0]), 64'd0);
      check("reset.m_ack", 64'(o_ack[0]), 64'd0);
      edge_();
      rst = 1'b0;
      cyc1();

      // Single request from master 1.
      m_adr[AW +: AW] = 32'h0000_1000;
      m_adr[0 +: AW]  = 32'h0000_2000;
      m_sel           = '1;
      m_cyc = 2'b10; m_stb = 2'b10;
      half();
      check("single.pre_cyc", 64'(o_s_cyc[0]), 64'd0);
      edge_();
      half();
      check("single.cyc", 64'(o_s_cyc[0]), 64'd1);
      check("single.adr", 64'(o_s_adr[0]), 64'h1000);
      check("single.grant", 64'(o_grant[0]), 64'b10);
      check("single.no_ack_yet", 64'(o_ack[0]), 64'd0);
      edge_();
      s_ack = 1'b1; s_dat = 32'hCAFE_0001;
      half();
      check("single.ack", 64'(o_ack[0]), 64'b10);
      check("single.rdata", 64'(o_m_dat[0]), 64'hCAFE_0001);
      edge_();
      s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
      half();
      check("single.release_cyc", 64'(o_s_cyc[0]), 64'd0);
      edge_();
      half();
      check("single.idle_grant", 64'(o_grant[0]), 64'd0);
      edge_();

      // Round-robin contention.
      do_reset();
      contend(0, 40);
      check("rr.seq_len", 64'(gseq.size()), 64'd4);
      if (gseq.size() == 4) begin
         check("rr.seq0", 64'(gseq[0]), 64'b01);
         check("rr.seq1", 64'(gseq[1]), 64'b10);
         check("rr.seq2", 64'(gseq[2]), 64'b01);
         check("rr.seq3", 64'(gseq[3]), 64'b10);
      end

      // Fixed priority under the same traffic; master 1 only after master 0 goes quiet.
      do_reset();
      contend(1, 40);
      check("fx.seq_len", 64'(gseq.size()), 64'd4);
      if (gseq.size() == 4) begin
         check("fx.seq0", 64'(gseq[0]), 64'b01);
         check("fx.seq1", 64'(gseq[1]), 64'b01);
         check("fx.seq2", 64'(gseq[2]), 64'b01);
         check("fx.seq3", 64'(gseq[3]), 64'b01);
      end
      m_cyc = 2'b10; m_stb = 2'b10;
      found = 1'b0;
      for (int i = 0; i < 6; i++) begin
         half();
         if (o_grant[1] == 2'b10) found = 1'b1;
         edge_();
      end
      check("fx.m1_after_m0_idle", 64'(found), 64'd1);

      // Burst hold: master 0 runs four beats while master 1 waits.
      do_reset();
      m_cyc = 2'b11; m_stb = 2'b11;
      m_cti[3 +: 3] = CTI_CLASSIC;
      beats = 0;
      for (int i = 0; i < 20 && beats < 4; i++) begin
         m_cti[0 +: 3] = (beats == 3) ? CTI_END_BURST : CTI_INC_BURST;
         #1;
         s_ack = o_s_stb[0];
         half();
         if (o_ack[0][0]) begin
            check($sformatf("burst.grant_beat%0d", beats), 64'(o_grant[0]), 64'b01);
            if (beats == 3) check("burst.end_cti", 64'(o_s_cti[0]), 64'(CTI_END_BURST));
            beats++;
         end
         edge_();
      end
      check("burst.beats", 64'(beats), 64'd4);
      s_ack = 1'b0; m_cyc = 2'b10; m_stb = 2'b10;
      half();
      check("burst.release_grant", 64'(o_grant[0]), 64'b01);
      check("burst.release_cyc", 64'(o_s_cyc[0]), 64'd0);
      edge_();
      half();
      check("burst.dead_cycle", 64'(o_grant[0]), 64'd0);
      edge_();
      half();
      check("burst.next_grant", 64'(o_grant[0]), 64'b10);
      edge_();

      // Watchdog: slave never answers master 0.
      do_reset();
      m_cti = '0;
      m_cyc = 2'b01; m_stb = 2'b01;
      cyc1();
      for (int k = 1; k <= TO + 1; k++) begin
         half();
         if (k <= TO) begin
            check($sformatf("tmo.no_err_%0d", k), 64'(o_err[0]), 64'd0);
         end else begin
            check("tmo.err", 64'(o_err[0]), 64'b01);
            check("tmo.stb_forced", 64'(o_s_stb[0]), 64'd0);
            check("tmo.no_ack", 64'(o_ack[0]), 64'd0);
         end
         edge_();
      end
      half();
      check("tmo.err_one_cycle", 64'(o_err[0]), 64'd0);
      check("tmo.stb_back", 64'(o_s_stb[0]), 64'd1);
      edge_();
      m_cyc = 2'b00; m_stb = 2'b00;
      cyc1();
      m_cyc = 2'b01; m_stb = 2'b01;
      cyc1();
      s_ack = 1'b1;
      half();
      check("tmo.retry_ack", 64'(o_ack[0]), 64'b01);
      check("tmo.retry_no_err", 64'(o_err[0]), 64'd0);
      edge_();
      clear_inputs();
      cyc1();

      // Asynchronous reset in the middle of a burst.
      do_reset();
      m_cyc = 2'b01; m_stb = 2'b01; m_cti[0 +: 3] = CTI_INC_BURST;
      cyc1();
      s_ack = 1'b1;
      half();
      check("areset.pre_cyc", 64'(o_s_cyc[0]), 64'd1);
      edge_();
      cyc1();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("areset.cyc_async", 64'(o_s_cyc[0]), 64'd0);
      check("areset.stb_async", 64'(o_s_stb[0]), 64'd0);
      check("areset.grant_async", 64'(o_grant[0]), 64'd0);
      cyc1();
      rst = 1'b0;
      s_ack = 1'b0;
      m_cyc = 2'b11; m_stb = 2'b11; m_cti = '0;
      cyc1();
      half();
      check("areset.restart_m0", 64'(o_grant[0]), 64'b01);
      edge_();

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(7) == 0) m_cyc[k] = ~m_cyc[k];
            m_stb[k] = m_cyc[k] & ($urandom_range(3) != 0);
         end
         m_adr = {$urandom, $urandom};
         m_dat = {$urandom, $urandom};
         m_sel = N*SW'($urandom);
         m_we  = N'($urandom);
         m_cti = (N*3)'($urandom);
         m_bte = (N*2)'($urandom);
         s_dat = $urandom;
         s_ack = ($urandom_range(7) == 0);
         s_err = ($urandom_range(31) == 0);
         s_rty = ($urandom_range(31) == 0);
         cyc1();
      end
      clear_inputs();
      repeat (3) cyc1();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mor1kx_wb_arbiter.md
Name: mor1kx_wb_arbiter

Overview:
- Parametrised N-master to 1-slave Wishbone B3 bus arbiter.
- Sits between the mor1kx iwbm/dwbm master ports (plus optional extra masters such as a debug DMA) and a single board-level Wishbone slave port.
- Supports fixed-priority or round-robin arbitration, holds the grant for the whole cycle (bursts included), and has a per-transfer timeout watchdog that returns err to a stalled master.

Parameters:
- NUM_MASTERS, 2, number of master ports (2..8); index 0 is the mor1kx instruction bus, index 1 the data bus.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; sel width is DATA_WIDTH/8.
- ARB_MODE, "ROUND_ROBIN", "ROUND_ROBIN" or "FIXED" (lowest index wins).
- TIMEOUT_CYCLES, 255, maximum number of wait cycles with no ack/err/rty before err is forced; 0 disables the watchdog; must fit in 16 bits.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  master addresses, packed with master k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  master write data.
- m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  byte selects.
- m_we_i, m_cyc_i, m_stb_i  in  NUM_MASTERS  per-master control.
- m_cti_i  in  NUM_MASTERS*3  cycle type identifiers.
- m_bte_i  in  NUM_MASTERS*2  burst type extensions.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
- m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS  per-master terminations.
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  out  (matching widths)  slave side.
- s_dat_i, s_ack_i, s_err_i, s_rty_i  in  (matching widths)  slave responses.
- grant_o  out  NUM_MASTERS  one-hot current grant, for debug and performance counters.

Behaviour:
- Reset (async, rst=1): state IDLE, grant_o=0, round-robin pointer last=NUM_MASTERS-1, watchdog count=0.
  - All slave outputs are 0.
  - All m_ack_o/m_err_o/m_rty_o are 0.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any m_cyc_i is high, register a one-hot grant and move to BUSY.
  - FIXED mode: the lowest set index wins.
  - ROUND_ROBIN mode: search starts at (last+1) mod NUM_MASTERS, wrapping; last is updated to the winner.
  - Arbitration latency is 1 cycle: s_cyc_o rises the cycle after the request is seen.
- BUSY:
  - Slave outputs are a combinational mux of the granted master's signals; s_cyc_o/s_stb_o come from that master.
  - Responses are routed only to the granted master: m_ack_o[g]=s_ack_i&m_stb_i[g], and likewise for err and rty. Non-granted terminations are 0.
  - m_dat_o=s_dat_i whenever a master is granted, else 0.
- Release: when the granted m_cyc_i drops, the next state is IDLE and grant_o=0.
  - Slave outputs go to 0 combinationally in that same cycle, since cyc follows the master.
  - There is exactly one dead cycle before the next grant.
  - Burst end (cti=3'b111 with ack) does not release by itself; the master's cyc governs release.
- Non-granted masters see no termination and keep waiting; their requests are never dropped.
- Watchdog (TIMEOUT_CYCLES>0):
  - In BUSY, count increments on each cycle with s_stb_o=1 and none of ack/err/rty.
  - Count clears on any termination, and on leaving BUSY.
  - When count==TIMEOUT_CYCLES, m_err_o[g] pulses for 1 cycle and s_stb_o is forced low that cycle; count then clears.
  - A real slave ack in the same cycle takes precedence: ack, no err.
- Simultaneous events:
  - Several requests arriving in IDLE are resolved by the mode rules.
  - A master raising cyc in the cycle the owner drops it is granted on the following IDLE cycle.
- Reset mid-transfer: everything returns to reset values immediately, including s_cyc_o=0 asynchronously.
- NUM_MASTERS=1: degenerates to a registered-grant pass-through with the watchdog still active.

Decomposition:
- Package mor1kx_wb_arb_pkg holds:
  - state encoding constants (IDLE=1'b0, BUSY=1'b1);
  - CTI constants (CLASSIC=3'b000, INC_BURST=3'b010, END_BURST=3'b111);
  - the ARB_MODE string constants.
- One sub-module, mor1kx_wb_arb_rr: a combinational one-hot round-robin/fixed priority picker, taking req, last pointer and mode and producing one-hot grant plus encoded index.
- The top module holds the FSM, the mux and the watchdog.

Test Plan:
- Single request: m_cyc_i[1]=m_stb_i[1]=1, adr=0x1000, slave acks 2 cycles later → s_cyc_o=1 one cycle after the request, s_adr_o=0x1000, m_ack_o=2'b10 on the ack cycle, m_ack_o[0] stays 0.
- Round-robin contention: both masters hold cyc continuously, each doing single classic transfers and dropping cyc after each ack → grants alternate 01,10,01,10 with one idle cycle between them.
- FIXED mode, same stimulus → master 0 is granted every time; master 1 is granted only once master 0 idles.
- Burst hold: master 0 issues a 4-beat incrementing burst (cti 010,010,010,111) while master 1 requests → grant_o stays 01 for all 4 acks and switches to 10 only after m_cyc_i[0] falls.
- Timeout with TIMEOUT_CYCLES=8, slave never acks → m_err_o[0] pulses on the 9th stalled cycle (count==8), no ack is seen, and the master retries cleanly afterwards.
- Async reset asserted mid-burst → s_cyc_o/s_stb_o go to 0 without a clock edge; after release, grant restarts from master 0 (last=NUM_MASTERS-1).
